mdma_48bx512_secded_ram: RTL and testbench
==========================================

Name: mdma_48bx512_secded_ram

Overview:
- Responder (RAM-side) end of the 48-bit x 512 descriptor-request FIFO RAM interface.
- Accepts write and read requests from the FIFO write engine.
- Stores each 48-bit word with a 7-bit SECDED code, returns read data at fixed 2-cycle latency, and flags single-bit (corrected) and double-bit (uncorrectable) errors.
- Sits under the descriptor request FIFO, replacing the generic RAM macro in both simulation and FPGA builds.

Parameters:
DATA_BITS, 48, data width per word; ECC width fixed at 7 for 48.
DEPTH, 512, number of words; ADDR_BITS = $clog2(DEPTH) = 9.
CNT_BITS, 16, width of the saturating error counters.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
wadr  input  ADDR_BITS  write address
wen  input  1  write enable
wdat  input  DATA_BITS  write data
ren  input  1  read enable
radr  input  ADDR_BITS  read address
rdat  output  DATA_BITS  read data (corrected where possible)
rsbe  output  1  single-bit error detected and corrected on this return
rdbe  output  1  double-bit error detected; rdat uncorrected
inj_sbe  input  1  on a write, flip stored data bit 0
inj_dbe  input  1  on a write, flip stored data bits 0 and 1
sbe_cnt  output  CNT_BITS  saturating count of rsbe returns
dbe_cnt  output  CNT_BITS  saturating count of rdbe returns
clr_cnt  input  1  synchronous clear of both counters

Behaviour:
Clock and reset:
- Single clock clk; reset rst is synchronous, active-high.
- Port names and directions match the slave side of the RAM interface (wadr, wen, wdat, ren, radr in; rdat, rsbe, rdbe out).

Reset:
- rdat=0, rsbe=0, rdbe=0, sbe_cnt=0, dbe_cnt=0; read pipeline valid bits cleared.
- Array contents are not reset; sim array initialised once to the all-zero codeword, which decodes clean.

Write:
- wen sampled high at edge E: encode wdat (Hamming, 6 check bits at codeword positions 1,2,4,8,16,32 over positions 1..54, plus overall parity bit p0 over all 54 bits).
- Injection is applied after encoding. inj_dbe takes precedence over inj_sbe.
- Store the 55-bit codeword at wadr on edge E.

Read:
- Stage 1: ren sampled high at edge E registers the array codeword at radr and sets v1.
- Stage 2: at edge E+1, decode and register rdat/rsbe/rdbe.
- Outputs are valid in the cycle after edge E+1 (latency 2).
- When ren is low, rdat holds its last value; rsbe/rdbe are 1 only in the return cycle of an error read and are 0 otherwise.
- Back-to-back reads every cycle are supported; full throughput.

Decode:
- syndrome s=0, parity ok: clean, rdat=data.
- s!=0 and s<=54, parity bad: flip bit s, rsbe=1.
- s=0, parity bad: p0 error; data clean, rsbe=1.
- s!=0, parity ok: rdbe=1, rdat=raw uncorrected data.
- s>54, parity bad: rdbe=1.
- rsbe and rdbe are never both 1.

Collision:
- wen and ren in the same cycle to the same address is read-first: the read returns the old codeword, and the new data is visible to a read issued one cycle later.

Counters:
- Increment on each rsbe/rdbe return; saturate at all-ones.
- clr_cnt clears both counters and wins over a same-cycle increment.

Reset mid-operation:
- In-flight reads are dropped; no return and no flags after reset.
- A write sampled on the same edge as rst is not performed.

Test Plan:
- Write 0x123456789ABC to address 5, read address 5 -> cycle+2 rdat=0x123456789ABC, rsbe=0, rdbe=0.
- Write 0xFFFFFFFFFFFF to address 511 with inj_sbe=1, read -> rdat=0xFFFFFFFFFFFF, rsbe=1 for one cycle, sbe_cnt=1.
- Write 0x000000000003 to address 0 with inj_dbe=1, read -> rdbe=1, rdat=0x000000000000 (raw), dbe_cnt=1, rsbe=0.
- Address 7 holds 0xAAAA; same cycle wen=1 wadr=7 wdat=0x5555 and ren=1 radr=7, then read 7 again -> first return 0xAAAA, second 0x5555.
- Stream reads of addresses 0..511 every cycle after writing addr=data -> 512 consecutive correct returns, no bubbles; rdat holds 511 afterwards.
- Issue ren, assert rst the next cycle -> no error flags, rdat=0 after reset. Force 65536 sbe reads -> sbe_cnt=0xFFFF saturated; clr_cnt -> 0.

Source files
------------

// File: rtl/mdma_48bx512_secded_ram.sv
`default_nettype none
// ============================================================================
// Module      : mdma_48bx512_secded_ram
// Description : 48-bit x 512 SECDED-protected RAM, responder side of the
//               descriptor-request FIFO RAM interface, 2-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mdma_48bx512_secded_ram #(
    parameter  int DATA_BITS = 48,
    parameter  int DEPTH     = 512,
    parameter  int CNT_BITS  = 16,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] wadr,
    input  logic                 wen,
    input  logic [DATA_BITS-1:0] wdat,
    input  logic                 ren,
    input  logic [ADDR_BITS-1:0] radr,
    output logic [DATA_BITS-1:0] rdat,
    output logic                 rsbe,
    output logic                 rdbe,
    input  logic                 inj_sbe,
    input  logic                 inj_dbe,
    output logic [CNT_BITS-1:0]  sbe_cnt,
    output logic [CNT_BITS-1:0]  dbe_cnt,
    input  logic                 clr_cnt
);

    localparam int c_npos    = DATA_BITS + 6;   // Hamming positions 1..c_npos
    localparam int c_cw_bits = c_npos + 1;      // plus overall parity at bit 0

    logic [c_cw_bits-1:0] mem_q [DEPTH];
    logic [c_cw_bits-1:0] cw1_q;
    logic [c_cw_bits-1:0] wcw_d;

    logic [c_npos:1]      w_enc_raw;
    logic [c_npos:1]      w_enc_h;
    logic [c_npos:1]      w_corr;
    logic [5:0]           w_enc_chk;
    logic [5:0]           w_syn;
    logic                 w_pbad;
    logic                 w_sbe;
    logic                 w_dbe;
    logic [DATA_BITS-1:0] w_dec_dat;

    logic                 v1_d, v1_q;
    logic [DATA_BITS-1:0] rdat_d, rdat_q;
    logic                 rsbe_d, rsbe_q;
    logic                 rdbe_d, rdbe_q;
    logic [CNT_BITS-1:0]  sbe_cnt_d, sbe_cnt_q;
    logic [CNT_BITS-1:0]  dbe_cnt_d, dbe_cnt_q;

    // Data bits fill the non-power-of-two positions in ascending order.
    for (genvar p = 1; p <= c_npos; p++) begin : g_pos
        if ((p & (p - 1)) != 0) begin : g_data
            localparam int c_di = p - 1 - $clog2(p + 1);
            assign w_enc_raw[p]    = wdat[c_di];
            assign w_enc_h[p]      = wdat[c_di];
            assign w_dec_dat[c_di] = w_corr[p];
        end else begin : g_chk
            assign w_enc_raw[p] = 1'b0;
            assign w_enc_h[p]   = w_enc_chk[$clog2(p)];
        end
    end

    // Check bit k covers every position whose index has bit k set.
    for (genvar k = 0; k < 6; k++) begin : g_ham
        localparam logic [63:0] c_pat = {(32 >> k){{(1 << k){1'b1}}, {(1 << k){1'b0}}}};
        assign w_enc_chk[k] = ^(w_enc_raw & c_pat[c_npos:1]);
        assign w_syn[k]     = ^(cw1_q[c_npos:1] & c_pat[c_npos:1]);
    end

    always_comb begin
        wcw_d = {w_enc_h, ^w_enc_h};
        // Data bits 0 and 1 live at codeword positions 3 and 5.
        if (inj_dbe) begin
            wcw_d[3] = ~wcw_d[3];
            wcw_d[5] = ~wcw_d[5];
        end else if (inj_sbe) begin
            wcw_d[3] = ~wcw_d[3];
        end
    end

    always_comb begin
        w_pbad = ^cw1_q;
        w_sbe  = w_pbad && (w_syn <= 6'(c_npos));
        w_dbe  = (!w_pbad && (w_syn != 6'd0)) || (w_pbad && (w_syn > 6'(c_npos)));
        w_corr = cw1_q[c_npos:1];
        if (w_sbe && (w_syn != 6'd0)) begin
            w_corr = w_corr ^ ({{(c_npos - 1){1'b0}}, 1'b1} << (w_syn - 6'd1));
        end
    end

    always_comb begin
        v1_d      = ren;
        rdat_d    = v1_q ? w_dec_dat : rdat_q;
        rsbe_d    = v1_q && w_sbe;
        rdbe_d    = v1_q && w_dbe;
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        if (clr_cnt) begin
            sbe_cnt_d = '0;
            dbe_cnt_d = '0;
        end else begin
            if (rsbe_d && (sbe_cnt_q != '1)) sbe_cnt_d = sbe_cnt_q + CNT_BITS'(1);
            if (rdbe_d && (dbe_cnt_q != '1)) dbe_cnt_d = dbe_cnt_q + CNT_BITS'(1);
        end
    end

    // Array read and write share an edge: a same-address read sees old data.
    always_ff @(posedge clk) begin
        if (wen && !rst) mem_q[wadr] <= wcw_d;
        if (ren)         cw1_q       <= mem_q[radr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            rdat_q    <= '0;
            rsbe_q    <= 1'b0;
            rdbe_q    <= 1'b0;
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
        end else begin
            v1_q      <= v1_d;
            rdat_q    <= rdat_d;
            rsbe_q    <= rsbe_d;
            rdbe_q    <= rdbe_d;
            sbe_cnt_q <= sbe_cnt_d;
            dbe_cnt_q <= dbe_cnt_d;
        end
    end

    assign rdat    = rdat_q;
    assign rsbe    = rsbe_q;
    assign rdbe    = rdbe_q;
    assign sbe_cnt = sbe_cnt_q;
    assign dbe_cnt = dbe_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mdma_48bx512_secded_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdma_48bx512_secded_ram
// Description : Directed, table-driven self-checking bench for the SECDED RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdma_48bx512_secded_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  wadr, radr;
    logic        wen, ren;
    logic [47:0] wdat, rdat;
    logic        rsbe, rdbe;
    logic        inj_sbe, inj_dbe, clr_cnt;
    logic [15:0] sbe_cnt, dbe_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0]  adr;
        logic [47:0] dat;
        logic        isbe;
        logic        idbe;
        logic [47:0] exp_dat;
        logic        exp_sbe;
        logic        exp_dbe;
    } vec_t;

    vec_t vecs [7];

    mdma_48bx512_secded_ram dut (
        .clk     (clk),
        .rst     (rst),
        .wadr    (wadr),
        .wen     (wen),
        .wdat    (wdat),
        .ren     (ren),
        .radr    (radr),
        .rdat    (rdat),
        .rsbe    (rsbe),
        .rdbe    (rdbe),
        .inj_sbe (inj_sbe),
        .inj_dbe (inj_dbe),
        .sbe_cnt (sbe_cnt),
        .dbe_cnt (dbe_cnt),
        .clr_cnt (clr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_write(input logic [8:0] a, input logic [47:0] d,
                            input logic s, input logic db);
        wen = 1'b1; wadr = a; wdat = d; inj_sbe = s; inj_dbe = db;
        @(posedge clk); #1;
        wen = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
    endtask

    task automatic do_read(input logic [8:0] a);
        ren = 1'b1; radr = a;
        @(posedge clk); #1;
        ren = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_sbe_n;
        int exp_dbe_n;

        vecs[0] = '{9'd5,   48'h123456789ABC, 1'b0, 1'b0, 48'h123456789ABC, 1'b0, 1'b0};
        vecs[1] = '{9'd511, 48'hFFFFFFFFFFFF, 1'b1, 1'b0, 48'hFFFFFFFFFFFF, 1'b1, 1'b0};
        vecs[2] = '{9'd0,   48'h000000000003, 1'b0, 1'b1, 48'h000000000000, 1'b0, 1'b1};
        vecs[3] = '{9'd100, 48'h000000000000, 1'b1, 1'b0, 48'h000000000000, 1'b1, 1'b0};
        vecs[4] = '{9'd200, 48'h800000000000, 1'b0, 1'b1, 48'h800000000003, 1'b0, 1'b1};
        vecs[5] = '{9'd300, 48'hA5A5A5A5A5A5, 1'b0, 1'b0, 48'hA5A5A5A5A5A5, 1'b0, 1'b0};
        vecs[6] = '{9'd301, 48'h5A5A5A5A5A5A, 1'b1, 1'b1, 48'h5A5A5A5A5A59, 1'b0, 1'b1};

        rst = 1'b1; wen = 1'b0; ren = 1'b0; wadr = '0; radr = '0; wdat = '0;
        inj_sbe = 1'b0; inj_dbe = 1'b0; clr_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_rdat", 64'(rdat), 64'd0);
        chk("reset_flags", 64'({rsbe, rdbe}), 64'd0);
        chk("reset_cnts", 64'({sbe_cnt, dbe_cnt}), 64'd0);

        exp_sbe_n = 0;
        exp_dbe_n = 0;
        foreach (vecs[i]) begin
            do_write(vecs[i].adr, vecs[i].dat, vecs[i].isbe, vecs[i].idbe);
            do_read(vecs[i].adr);
            if (vecs[i].exp_sbe) exp_sbe_n++;
            if (vecs[i].exp_dbe) exp_dbe_n++;
            chk($sformatf("vec%0d_rdat", i), 64'(rdat), 64'(vecs[i].exp_dat));
            chk($sformatf("vec%0d_sbe", i), 64'(rsbe), 64'(vecs[i].exp_sbe));
            chk($sformatf("vec%0d_dbe", i), 64'(rdbe), 64'(vecs[i].exp_dbe));
            chk($sformatf("vec%0d_sbe_cnt", i), 64'(sbe_cnt), 64'(exp_sbe_n));
            chk($sformatf("vec%0d_dbe_cnt", i), 64'(dbe_cnt), 64'(exp_dbe_n));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_hold", i), 64'({rsbe, rdbe, rdat}), 64'({2'b00, vecs[i].exp_dat}));
        end

        // Same-cycle write and read to one address returns the old word.
        do_write(9'd7, 48'h00000000AAAA, 1'b0, 1'b0);
        wen = 1'b1; wadr = 9'd7; wdat = 48'h000000005555;
        ren = 1'b1; radr = 9'd7;
        @(posedge clk); #1;
        wen = 1'b0;
        @(posedge clk); #1;
        ren = 1'b0;
        chk("collide_old", 64'(rdat), 64'h00000000AAAA);
        @(posedge clk); #1;
        chk("collide_new", 64'(rdat), 64'h000000005555);

        for (int k = 0; k < 512; k++) begin
            wen = 1'b1; wadr = 9'(k); wdat = 48'(k);
            @(posedge clk); #1;
        end
        wen = 1'b0;
        for (int k = 0; k < 514; k++) begin
            if (k >= 2) chk($sformatf("stream%0d", k - 2), 64'({rsbe, rdbe, rdat}), 64'(k - 2));
            ren  = (k < 512);
            radr = 9'(k);
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1 chk("stream_hold", 64'(rdat), 64'd511);

        // Read in flight when reset arrives; a write on the reset edge is dropped.
        ren = 1'b1; radr = 9'd5;
        @(posedge clk); #1;
        ren = 1'b0; rst = 1'b1; wen = 1'b1; wadr = 9'd9; wdat = 48'h000000000777;
        @(posedge clk); #1;
        rst = 1'b0; wen = 1'b0;
        chk("rst_rdat", 64'({rsbe, rdbe, rdat}), 64'd0);
        chk("rst_cnts", 64'({sbe_cnt, dbe_cnt}), 64'd0);
        @(posedge clk); #1;
        chk("rst_no_return", 64'({rsbe, rdbe, rdat}), 64'd0);
        do_read(9'd9);
        chk("rst_write_dropped", 64'(rdat), 64'd9);

        do_write(9'd1, 48'h000000000001, 1'b1, 1'b0);
        ren = 1'b1; radr = 9'd1;
        repeat (65536) @(posedge clk);
        #1;
        chk("sat_reach", 64'(sbe_cnt), 64'hFFFF);
        @(posedge clk); #1;
        chk("sat_hold", 64'(sbe_cnt), 64'hFFFF);
        chk("sat_data", 64'({rsbe, rdbe, rdat}), 64'({2'b10, 48'h1}));
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0; ren = 1'b0;
        chk("clr_wins", 64'(sbe_cnt), 64'd0);
        @(posedge clk); #1;
        chk("cnt_after_clr", 64'(sbe_cnt), 64'd1);
        @(posedge clk); #1;
        chk("idle_no_flag", 64'({rsbe, rdbe, dbe_cnt}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
